// File: rtl/game_keys_pkg.sv
// Shared keycodes and state encoding for the keyboard event path.
package game_keys_pkg;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_P     = 8'h13;
  localparam logic [7:0] KEY_M     = 8'h10;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMING = 2'd1,
    HELD   = 2'd2
  } key_evt_state_t;

  // Pause and menu must act once per press, even with auto-repeat built in.
  function automatic logic key_repeats(input logic [7:0] code);
    return (code != KEY_P) && (code != KEY_M);
  endfunction

endpackage

// File: rtl/key_stable_timer.sv
// Candidate/counter stability filter: pulses accept in the cycle the counter
// reaches STABLE_CYCLES-1 with an unchanged candidate.
module key_stable_timer #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] code_in,
  output logic       accept,
  output logic [7:0] stable_code
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(STABLE_CYCLES - 1);

  logic [7:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (code_in != cand_q) begin
      cand_d = code_in;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    // Fire only on the transition into CNT_HIT so a saturated hold never re-accepts.
    accept = (cnt_d == CNT_HIT) && ((cand_d != cand_q) || (cnt_q != CNT_HIT));
  end

  assign stable_code = cand_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cand_q <= 8'h00;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/key_event_gen.sv
// Debounced keycode -> one-cycle event converter with jump/any-key levels.
// Optional auto-repeat is built when KEY_AUTO_REPEAT_EN is defined.
module key_event_gen
  import game_keys_pkg::*;
#(
`ifdef KEY_AUTO_REPEAT_EN
  parameter int         REPEAT_DELAY  = 25_000_000,
  parameter int         REPEAT_PERIOD = 5_000_000,
`endif
  parameter int         STABLE_CYCLES = 50000,
  parameter logic [7:0] JUMP_KEY      = KEY_W
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode_raw,
  output logic [7:0] keycode_evt,
  output logic       evt_valid,
  output logic       jump_held,
  output logic       key_down
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  key_evt_state_t state_q, state_d;
  logic [7:0]     raw_q;
  logic [7:0]     acc_q, acc_d;
  logic [7:0]     keycode_evt_q, keycode_evt_d;
  logic           evt_valid_q, evt_valid_d;
  logic           jump_held_q, jump_held_d;
  logic           key_down_q, key_down_d;
  logic           accept;
  logic [7:0]     stable_code;
  logic           evt_fire;

`ifdef KEY_AUTO_REPEAT_EN
  logic [31:0] rpt_cnt_q, rpt_cnt_d;
  logic        rpt_first_q, rpt_first_d;
  logic [31:0] rpt_limit;
`endif

  key_stable_timer #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .Clk        (Clk),
    .Reset      (Reset),
    .code_in    (raw_q),
    .accept     (accept),
    .stable_code(stable_code)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      raw_q         <= KEY_NONE;
      acc_q         <= KEY_NONE;
      keycode_evt_q <= KEY_NONE;
      evt_valid_q   <= 1'b0;
      jump_held_q   <= 1'b0;
      key_down_q    <= 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
      rpt_cnt_q     <= 32'd0;
      rpt_first_q   <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      raw_q         <= keycode_raw;
      acc_q         <= acc_d;
      keycode_evt_q <= keycode_evt_d;
      evt_valid_q   <= evt_valid_d;
      jump_held_q   <= jump_held_d;
      key_down_q    <= key_down_d;
`ifdef KEY_AUTO_REPEAT_EN
      rpt_cnt_q     <= rpt_cnt_d;
      rpt_first_q   <= rpt_first_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    evt_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (stable_code != KEY_NONE) begin
          if (accept) begin
            acc_d    = stable_code;
            evt_fire = 1'b1;
            state_d  = HELD;
          end else begin
            state_d = ARMING;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ARMING: begin
        if (stable_code == KEY_NONE) begin
          state_d = IDLE;
        end else if (accept) begin
          acc_d    = stable_code;
          evt_fire = 1'b1;
          state_d  = HELD;
        end else begin
          state_d = ARMING;
        end
      end
      HELD: begin
        if (accept) begin
          if (stable_code == KEY_NONE) begin
            acc_d   = KEY_NONE;
            state_d = IDLE;
          end else if (stable_code != acc_q) begin
            acc_d    = stable_code;
            evt_fire = 1'b1;
          end else begin
            state_d = HELD;
          end
        end else begin
          state_d = HELD;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = KEY_NONE;
      end
    endcase

`ifdef KEY_AUTO_REPEAT_EN
    // Any fresh acceptance, rollover or release restarts the repeat schedule.
    rpt_limit   = rpt_first_q ? 32'(REPEAT_DELAY) : 32'(REPEAT_PERIOD);
    rpt_cnt_d   = 32'd0;
    rpt_first_d = 1'b1;
    if ((state_q == HELD) && (state_d == HELD) && !evt_fire && key_repeats(acc_q)) begin
      rpt_first_d = rpt_first_q;
      if (rpt_cnt_q == rpt_limit - 32'd1) begin
        evt_fire    = 1'b1;
        rpt_cnt_d   = 32'd0;
        rpt_first_d = 1'b0;
      end else begin
        rpt_cnt_d = rpt_cnt_q + 32'd1;
      end
    end else begin
      rpt_cnt_d   = 32'd0;
      rpt_first_d = 1'b1;
    end
`endif
  end

  always_comb begin
    evt_valid_d = evt_fire;
    if (evt_fire) begin
      keycode_evt_d = acc_d;
    end else begin
      keycode_evt_d = KEY_NONE;
    end
    jump_held_d = (acc_d == JUMP_KEY);
    key_down_d  = (acc_d != KEY_NONE);
  end

  assign keycode_evt = keycode_evt_q;
  assign evt_valid   = evt_valid_q;
  assign jump_held   = jump_held_q;
  assign key_down    = key_down_q;

endmodule

// File: tb/tb_key_event_gen.sv
// Self-checking bench for key_event_gen with STABLE_CYCLES=4 (default build).
module tb_key_event_gen;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] raw = 8'h00;
  logic [7:0] keycode_evt;
  logic       evt_valid;
  logic       jump_held;
  logic       key_down;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] code;
    int         exp_cyc;
  } evt_t;

  typedef struct {
    logic [7:0] code;
    int         hold;
    bit         evt;
    bit         kd;
    bit         jh;
  } seg_t;

  evt_t exp_q[$];
  evt_t e;
  seg_t tbl[13];

  key_event_gen #(.STABLE_CYCLES(S)) dut (
    .Clk        (clk),
    .Reset      (reset),
    .keycode_raw(raw),
    .keycode_evt(keycode_evt),
    .evt_valid  (evt_valid),
    .jump_held  (jump_held),
    .key_down   (key_down)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Advance to the next falling edge and score any event the DUT shows there.
  task automatic tick();
    @(negedge clk);
    checks++;
    if (evt_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_evt: got code %h at cycle %0d, required no event", keycode_evt, cyc);
      end else begin
        e = exp_q.pop_front();
        if (keycode_evt !== e.code || cyc != e.exp_cyc) begin
          errors++;
          $display("FAIL evt: got code %h at cycle %0d, required code %h at cycle %0d",
                   keycode_evt, cyc, e.code, e.exp_cyc);
        end
      end
    end else if (keycode_evt !== 8'h00) begin
      errors++;
      $display("FAIL evt_idle_code: got %h with evt_valid=%b, required 00", keycode_evt, evt_valid);
    end
  endtask

  task automatic expect_evt(input logic [7:0] code);
    exp_q.push_back('{code: code, exp_cyc: cyc + S + 1});
  endtask

  initial begin
    tbl[0]  = '{8'h13, 20, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{8'h00, 10, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{8'h2C,  3, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{8'h00, 10, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{8'h1A, 12, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{8'h2C, 12, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{8'h00,  2, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{8'h2C, 10, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{8'h00,  4, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{8'h00, 10, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{8'h2C,  4, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{8'h2C,  6, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{8'h00, 10, 1'b0, 1'b0, 1'b0};

    repeat (3) tick();
    chk("rst_evt_valid", {7'd0, evt_valid}, 8'h00);
    chk("rst_keycode_evt", keycode_evt, 8'h00);
    chk("rst_jump_held", {7'd0, jump_held}, 8'h00);
    chk("rst_key_down", {7'd0, key_down}, 8'h00);
    reset = 1'b0;
    repeat (6) tick();

    for (int i = 0; i < 13; i++) begin
      raw = tbl[i].code;
      if (tbl[i].evt) expect_evt(tbl[i].code);
      repeat (tbl[i].hold) tick();
      chk($sformatf("seg%0d_key_down", i), {7'd0, key_down}, {7'd0, tbl[i].kd});
      chk($sformatf("seg%0d_jump_held", i), {7'd0, jump_held}, {7'd0, tbl[i].jh});
    end

    // Bouncing press: only the final stable hold counts.
    for (int i = 0; i < 10; i++) begin
      raw = 8'h13; tick(); tick();
      raw = 8'h00; tick(); tick();
    end
    raw = 8'h13;
    expect_evt(8'h13);
    repeat (15) tick();
    chk("bounce_key_down", {7'd0, key_down}, 8'h01);
    raw = 8'h00;
    repeat (S) tick();
    chk("release_edge_before", {7'd0, key_down}, 8'h01);
    tick();
    chk("release_edge_after", {7'd0, key_down}, 8'h00);
    repeat (5) tick();

    // Reset while an accepted jump key is held.
    raw = 8'h1A;
    expect_evt(8'h1A);
    repeat (8) tick();
    chk("pre_rst_jump_held", {7'd0, jump_held}, 8'h01);
    reset = 1'b1;
    tick();
    chk("mid_rst_evt_valid", {7'd0, evt_valid}, 8'h00);
    chk("mid_rst_keycode_evt", keycode_evt, 8'h00);
    chk("mid_rst_jump_held", {7'd0, jump_held}, 8'h00);
    chk("mid_rst_key_down", {7'd0, key_down}, 8'h00);
    repeat (2) tick();
    reset = 1'b0;
    expect_evt(8'h1A);
    repeat (10) tick();
    chk("post_rst_jump_held", {7'd0, jump_held}, 8'h01);
    chk("post_rst_key_down", {7'd0, key_down}, 8'h01);

    // Reset in the middle of a count: the aborted count yields nothing.
    raw = 8'h00;
    repeat (10) tick();
    raw = 8'h2C;
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    expect_evt(8'h2C);
    repeat (10) tick();
    chk("midcount_key_down", {7'd0, key_down}, 8'h01);
    chk("midcount_jump_held", {7'd0, jump_held}, 8'h00);

    raw = 8'h00;
    repeat (10) tick();
    chk("final_key_down", {7'd0, key_down}, 8'h00);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_evt: %0d expected events never seen, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
